// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: state/owner codes and default sizing.
package sdram_arb_pkg;

    localparam int unsigned DEF_BURST_LEN  = 8;
    localparam int unsigned DEF_STARVE_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR       = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_DRAIN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/arb_beat_counter.sv
// Beat counter for read bursts: synchronous clear, increment, terminal flag at BURST_LEN.
module arb_beat_counter #(
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned CW        = $clog2(BURST_LEN) + 1
) (
    input  logic          in_clk,
    input  logic          in_reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          term
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next-count selection; clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign term  = (count_q == CW'(BURST_LEN));

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller master port between the image loader (single writes)
// and the VGA line prefetcher (fixed-length read bursts); reads win unless a write is starved.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              in_clk,
    input  logic              in_reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_done,
    output logic [ADDR_W-1:0] sd_addr,
    output logic              sd_write,
    output logic [DATA_W-1:0] sd_writedata,
    output logic              sd_read,
    input  logic              sd_waitrequest,
    input  logic [DATA_W-1:0] sd_readdata,
    input  logic              sd_readdatavalid,
    output logic [1:0]        owner
);

    localparam int unsigned CW = $clog2(BURST_LEN) + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              wr_ack_q, wr_ack_d;
    logic              rd_ack_q, rd_ack_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_done_q, rd_done_d;
    logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
    logic              sd_write_q, sd_write_d;
    logic [DATA_W-1:0] sd_writedata_q, sd_writedata_d;
    logic              sd_read_q, sd_read_d;

    logic          issue_clr, issue_inc, issue_term;
    logic          ret_clr, ret_inc, ret_term;
    logic [CW-1:0] issue_cnt, ret_cnt;
    logic          starved, ret_ok;

    arb_beat_counter #(.BURST_LEN(BURST_LEN), .CW(CW)) u_issue_cnt (
        .in_clk(in_clk), .in_reset(in_reset), .clr(issue_clr), .inc(issue_inc),
        .count(issue_cnt), .term(issue_term)
    );

    arb_beat_counter #(.BURST_LEN(BURST_LEN), .CW(CW)) u_ret_cnt (
        .in_clk(in_clk), .in_reset(in_reset), .clr(ret_clr), .inc(ret_inc),
        .count(ret_cnt), .term(ret_term)
    );

    assign starved = wr_req && (starve_q >= SW'(STARVE_MAX));
    // Returns outside a burst window are a controller protocol error and are discarded.
    assign ret_ok  = sd_readdatavalid && !ret_term &&
                     ((state_q == ST_RD_ISSUE) || (state_q == ST_RD_DRAIN));

    // Grant decision, command generation, return forwarding and starvation tracking.
    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        starve_d       = starve_q;
        wr_ack_d       = 1'b0;
        rd_ack_d       = 1'b0;
        rd_valid_d     = 1'b0;
        rd_data_d      = rd_data_q;
        rd_done_d      = 1'b0;
        sd_addr_d      = sd_addr_q;
        sd_write_d     = sd_write_q;
        sd_writedata_d = sd_writedata_q;
        sd_read_d      = sd_read_q;
        issue_clr      = 1'b0;
        issue_inc      = 1'b0;
        ret_clr        = 1'b0;
        ret_inc        = 1'b0;

        if (ret_ok) begin
            ret_inc    = 1'b1;
            rd_valid_d = 1'b1;
            rd_data_d  = sd_readdata;
            rd_done_d  = (ret_cnt == CW'(BURST_LEN - 1));
        end else begin
            ret_inc    = 1'b0;
        end

        if ((state_q != ST_WR) && wr_req && (starve_q < SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rd_req && !starved) begin
                    state_d   = ST_RD_ISSUE;
                    rd_ack_d  = 1'b1;
                    base_d    = rd_addr;
                    sd_addr_d = rd_addr;
                    sd_read_d = 1'b1;
                    issue_clr = 1'b1;
                    ret_clr   = 1'b1;
                end else if (wr_req) begin
                    state_d        = ST_WR;
                    sd_write_d     = 1'b1;
                    sd_addr_d      = wr_addr;
                    sd_writedata_d = wr_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                if (!sd_waitrequest) begin
                    state_d    = ST_IDLE;
                    sd_write_d = 1'b0;
                    wr_ack_d   = 1'b1;
                    starve_d   = '0;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_RD_ISSUE: begin
                if (!sd_waitrequest && !issue_term) begin
                    issue_inc = 1'b1;
                    if (issue_cnt == CW'(BURST_LEN - 1)) begin
                        state_d   = ST_RD_DRAIN;
                        sd_read_d = 1'b0;
                    end else begin
                        sd_addr_d = base_q + ADDR_W'(issue_cnt) + ADDR_W'(1);
                    end
                end else begin
                    issue_inc = 1'b0;
                end
            end
            ST_RD_DRAIN: begin
                if (ret_term) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RD_DRAIN;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                sd_read_d  = 1'b0;
                sd_write_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q        <= ST_IDLE;
            base_q         <= '0;
            starve_q       <= '0;
            wr_ack_q       <= 1'b0;
            rd_ack_q       <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
            rd_done_q      <= 1'b0;
            sd_addr_q      <= '0;
            sd_write_q     <= 1'b0;
            sd_writedata_q <= '0;
            sd_read_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            starve_q       <= starve_d;
            wr_ack_q       <= wr_ack_d;
            rd_ack_q       <= rd_ack_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
            rd_done_q      <= rd_done_d;
            sd_addr_q      <= sd_addr_d;
            sd_write_q     <= sd_write_d;
            sd_writedata_q <= sd_writedata_d;
            sd_read_q      <= sd_read_d;
        end
    end

    assign wr_ack       = wr_ack_q;
    assign rd_ack       = rd_ack_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_done      = rd_done_q;
    assign sd_addr      = sd_addr_q;
    assign sd_write     = sd_write_q;
    assign sd_writedata = sd_writedata_q;
    assign sd_read      = sd_read_q;
    assign owner        = state_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed testbench for sdram_port_arbiter with a fixed 3-cycle read-latency SDRAM model.
module tb_sdram_port_arbiter;

    logic        in_clk = 1'b0;
    logic        in_reset = 1'b0;
    logic        wr_req = 1'b0;
    logic [24:0] wr_addr = 25'd0;
    logic [15:0] wr_data = 16'd0;
    logic        wr_ack;
    logic        rd_req = 1'b0;
    logic [24:0] rd_addr = 25'd0;
    logic        rd_ack, rd_valid, rd_done;
    logic [15:0] rd_data;
    logic [24:0] sd_addr;
    logic        sd_write, sd_read;
    logic [15:0] sd_writedata;
    logic        sd_waitrequest = 1'b0;
    logic [15:0] sd_readdata = 16'd0;
    logic        sd_readdatavalid = 1'b0;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;
    logic hold_rd = 1'b0;

    logic        p0 = 1'b0, p1 = 1'b0, p2 = 1'b0;
    logic [15:0] d0 = 16'd0, d1 = 16'd0, d2 = 16'd0;
    logic [24:0] acc_q[$];
    logic [15:0] beat_q[$];
    int          done_q[$];
    int          ev_q[$];
    logic [1:0]  own_q[$];

    sdram_port_arbiter dut (
        .in_clk(in_clk), .in_reset(in_reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
        .sd_addr(sd_addr), .sd_write(sd_write), .sd_writedata(sd_writedata), .sd_read(sd_read),
        .sd_waitrequest(sd_waitrequest), .sd_readdata(sd_readdata),
        .sd_readdatavalid(sd_readdatavalid), .owner(owner)
    );

    always #5 in_clk = ~in_clk;

    // SDRAM model and logger: data returns 3 cycles after an accepted read, value = addr ^ 5A5A.
    always @(negedge in_clk) begin
        if (sd_read && !sd_waitrequest) acc_q.push_back(sd_addr);
        if (rd_valid) begin
            beat_q.push_back(rd_data);
            if (rd_done) done_q.push_back(beat_q.size());
        end
        if (rd_ack) ev_q.push_back(2);
        if (wr_ack) ev_q.push_back(1);
        if (own_q.size() == 0 || own_q[own_q.size()-1] != owner) own_q.push_back(owner);
        sd_readdatavalid = p2;
        sd_readdata      = d2;
        p2 = p1; d2 = d1;
        p1 = p0; d1 = d0;
        p0 = sd_read && !sd_waitrequest;
        d0 = sd_addr[15:0] ^ 16'h5A5A;
    end

    task automatic tick();
        @(posedge in_clk);
        #1;
        if (rd_ack && !hold_rd) rd_req = 1'b0;
        if (wr_ack) wr_req = 1'b0;
    endtask

    task automatic clear_logs();
        acc_q.delete(); beat_q.delete(); done_q.delete(); ev_q.delete(); own_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge in_clk);
        #1;
        checks++;
        if ({sd_write, sd_read, sd_addr, sd_writedata} !== 67'd0) begin
            errors++; $display("FAIL reset_sd: got %0h expected 0", {sd_write, sd_read, sd_addr, sd_writedata});
        end
        checks++;
        if ({wr_ack, rd_ack, rd_valid, rd_done, rd_data, owner} !== 22'd0) begin
            errors++; $display("FAIL reset_rd: got %0h expected 0", {wr_ack, rd_ack, rd_valid, rd_done, rd_data, owner});
        end
        in_reset = 1'b1;
    endtask

    task automatic test_single_write();
        clear_logs();
        wr_addr = 25'd5; wr_data = 16'hBEEF; wr_req = 1'b1;
        tick();
        checks++;
        if (owner !== 2'd1 || sd_write !== 1'b1 || sd_addr !== 25'd5 || sd_writedata !== 16'hBEEF) begin
            errors++; $display("FAIL wr_cmd: got owner=%0d wr=%0b addr=%0h data=%0h expected 1 1 5 beef",
                               owner, sd_write, sd_addr, sd_writedata);
        end
        checks++;
        if (wr_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_early: got %0b expected 0", wr_ack); end
        tick();
        checks++;
        if (wr_ack !== 1'b1 || sd_write !== 1'b0 || owner !== 2'd0) begin
            errors++; $display("FAIL wr_ack: got ack=%0b wr=%0b owner=%0d expected 1 0 0", wr_ack, sd_write, owner);
        end
        tick();
        checks++;
        if (wr_ack !== 1'b0 || owner !== 2'd0) begin
            errors++; $display("FAIL wr_after: got ack=%0b owner=%0d expected 0 0", wr_ack, owner);
        end
    endtask

    task automatic test_read_burst(input logic [24:0] base);
        logic [24:0] e;
        clear_logs();
        rd_addr = base; rd_req = 1'b1;
        tick();
        checks++;
        if (rd_ack !== 1'b1 || sd_read !== 1'b1 || sd_addr !== base || owner !== 2'd2) begin
            errors++; $display("FAIL rd_grant: got ack=%0b rd=%0b addr=%0h owner=%0d expected 1 1 %0h 2",
                               rd_ack, sd_read, sd_addr, owner, base);
        end
        repeat (30) tick();
        checks++;
        if (acc_q.size() != 8) begin errors++; $display("FAIL rd_issue_count: got %0d expected 8", acc_q.size()); end
        checks++;
        if (beat_q.size() != 8) begin errors++; $display("FAIL rd_beat_count: got %0d expected 8", beat_q.size()); end
        for (int i = 0; i < 8; i++) begin
            e = base + 25'(i);
            if (i < acc_q.size()) begin
                checks++;
                if (acc_q[i] !== e) begin errors++; $display("FAIL rd_addr[%0d]: got %0h expected %0h", i, acc_q[i], e); end
            end
            if (i < beat_q.size()) begin
                checks++;
                if (beat_q[i] !== (e[15:0] ^ 16'h5A5A)) begin
                    errors++; $display("FAIL rd_data[%0d]: got %0h expected %0h", i, beat_q[i], e[15:0] ^ 16'h5A5A);
                end
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != 8) begin
            errors++; $display("FAIL rd_done: got %0d pulses (first at %0d) expected 1 at 8",
                               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
        end
        checks++;
        if (owner !== 2'd0) begin errors++; $display("FAIL rd_end_owner: got %0d expected 0", owner); end
    endtask

    task automatic test_simultaneous();
        clear_logs();
        rd_addr = 25'd200; wr_addr = 25'd7; wr_data = 16'h1234;
        rd_req = 1'b1; wr_req = 1'b1;
        repeat (30) tick();
        checks++;
        if (ev_q.size() != 2 || ev_q[0] != 2 || ev_q[1] != 1) begin
            errors++; $display("FAIL both_order: got %0d events first=%0d expected rd_ack(2) then wr_ack(1)",
                               ev_q.size(), (ev_q.size() > 0) ? ev_q[0] : -1);
        end
        checks++;
        if (own_q.size() != 6 || own_q[1] !== 2'd2 || own_q[2] !== 2'd3 || own_q[3] !== 2'd0 ||
            own_q[4] !== 2'd1 || own_q[5] !== 2'd0) begin
            errors++; $display("FAIL both_owner_seq: got %0d owner changes expected 6 (0,2,3,0,1,0)", own_q.size());
        end
    endtask

    task automatic test_starvation();
        int nrd;
        bit seen;
        clear_logs();
        nrd = 0; seen = 1'b0;
        hold_rd = 1'b1;
        rd_addr = 25'd300; wr_addr = 25'd9; wr_data = 16'h0F0F;
        rd_req = 1'b1; wr_req = 1'b1;
        for (int c = 0; c < 200 && !seen; c++) begin
            tick();
            if (wr_ack) begin
                seen = 1'b1; hold_rd = 1'b0; rd_req = 1'b0;
            end
        end
        hold_rd = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        repeat (30) tick();
        checks++;
        if (!seen) begin errors++; $display("FAIL starve_timeout: got no wr_ack expected one within 200 cycles"); end
        for (int i = 0; i < ev_q.size() && ev_q[i] == 2; i++) nrd++;
        checks++;
        if (nrd != 5) begin errors++; $display("FAIL starve_grants: got %0d rd_ack before wr_ack expected 5", nrd); end
        checks++;
        if (owner !== 2'd0) begin errors++; $display("FAIL starve_end_owner: got %0d expected 0", owner); end
    endtask

    task automatic test_waitrequest();
        int stalls;
        logic [24:0] base;
        base = 25'd400;
        stalls = 0;
        clear_logs();
        rd_addr = base; rd_req = 1'b1;
        tick();
        for (int c = 0; c < 60; c++) begin
            if (stalls > 0 && stalls < 10) begin
                checks++;
                if (sd_addr !== base + 25'd2 || sd_read !== 1'b1) begin
                    errors++; $display("FAIL stall_stable: got addr=%0h rd=%0b expected %0h 1", sd_addr, sd_read, base + 25'd2);
                end
                sd_waitrequest = 1'b1; stalls++;
            end else if (stalls == 0 && sd_read && sd_addr == base + 25'd2) begin
                sd_waitrequest = 1'b1; stalls = 1;
            end else begin
                sd_waitrequest = 1'b0;
            end
            tick();
        end
        sd_waitrequest = 1'b0;
        checks++;
        if (stalls != 10) begin errors++; $display("FAIL stall_len: got %0d expected 10", stalls); end
        checks++;
        if (acc_q.size() != 8) begin errors++; $display("FAIL stall_issue_count: got %0d expected 8", acc_q.size()); end
        for (int i = 0; i < acc_q.size() && i < 8; i++) begin
            checks++;
            if (acc_q[i] !== base + 25'(i)) begin
                errors++; $display("FAIL stall_addr[%0d]: got %0h expected %0h", i, acc_q[i], base + 25'(i));
            end
        end
        checks++;
        if (beat_q.size() != 8 || done_q.size() != 1) begin
            errors++; $display("FAIL stall_beats: got %0d beats %0d done expected 8 1", beat_q.size(), done_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        int c;
        clear_logs();
        rd_addr = 25'd500; rd_req = 1'b1;
        c = 0;
        while (acc_q.size() < 4 && c < 20) begin tick(); c++; end
        checks++;
        if (acc_q.size() != 4) begin errors++; $display("FAIL mid_reach: got %0d accepts expected 4", acc_q.size()); end
        in_reset = 1'b0;
        #1;
        checks++;
        if ({sd_write, sd_read, sd_addr, sd_writedata, wr_ack, rd_ack, rd_valid, rd_done, rd_data, owner} !== 89'd0) begin
            errors++; $display("FAIL mid_async: got rd=%0b addr=%0h owner=%0d rd_valid=%0b expected all 0",
                               sd_read, sd_addr, owner, rd_valid);
        end
        beat_q.delete();
        rd_req = 1'b0;
        @(posedge in_clk);
        #1;
        in_reset = 1'b1;
        repeat (10) tick();
        checks++;
        if (beat_q.size() != 0) begin errors++; $display("FAIL mid_stale: got %0d rd_valid beats expected 0", beat_q.size()); end
        checks++;
        if (owner !== 2'd0 || sd_read !== 1'b0) begin
            errors++; $display("FAIL mid_idle: got owner=%0d rd=%0b expected 0 0", owner, sd_read);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_burst(25'd100);
        test_simultaneous();
        test_starvation();
        test_waitrequest();
        test_reset_mid_burst();
        test_read_burst(25'h1FFFFFC);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion before 200000 ns");
        $fatal(1);
    end

endmodule
